// File: rtl/axis_frame_source.sv
// AXI-Stream frame source: samples -> FWFT FIFO -> framed beats.
// Frames are closed with zero pad beats when capture stops mid-frame.
module axis_frame_source #(
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 256
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic [15:0] sample_data,
  input  logic        sample_valid,
  output logic [15:0] tdata,
  output logic [1:0]  tstrb,
  output logic [1:0]  tkeep,
  output logic        tlast,
  output logic        tuser,
  output logic        tvalid,
  input  logic        tready,
  output logic        overflow,
  input  logic        overflow_clr,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [15:0] LAST_CNT = 16'(FRAME_LEN - 1);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  logic [1:0]  state;
  logic [1:0]  state_nx;
  logic [15:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [15:0] beat_cnt;

  logic empty;
  logic full;
  logic wr_en;
  logic rd_en;
  logic drop;
  logic pad;
  logic xfer;

  // Extra pointer MSB distinguishes full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign wr_en = (state == RUN) && sample_valid && !full;
  assign drop  = (state == RUN) && sample_valid && full;
  assign pad   = (state == DRAIN) && empty && (beat_cnt != '0);

  assign tvalid = !empty || pad;
  assign xfer   = tvalid && tready;
  assign rd_en  = xfer && !empty;

  assign tdata = empty ? 16'h0000 : mem[rd_ptr[AW-1:0]];
  assign tkeep = empty ? 2'b00 : 2'b11;
  assign tstrb = tkeep;
  assign tuser = tvalid && (beat_cnt == '0);
  assign tlast = tvalid && (beat_cnt == LAST_CNT);
  assign busy  = (state != IDLE);

  // Capture session control; DRAIN only exits on a frame boundary.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (enable) state_nx = RUN;
      RUN:     if (!enable) state_nx = DRAIN;
      DRAIN:   if (empty && (beat_cnt == '0)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nx;
  end

  // Sample storage; contents are don't-care while the FIFO is empty.
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= sample_data;
  end

  // FIFO pointers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Position within the frame, advanced by data and pad beats alike.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                    beat_cnt <= '0;
    else if (xfer && tlast)          beat_cnt <= '0;
    else if (xfer)                   beat_cnt <= beat_cnt + 16'd1;
  end

  // Sticky drop flag; a new drop beats a simultaneous clear.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)          overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_axis_frame_source.sv
// Bench for axis_frame_source: scoreboard of expected beats,
// one task per scenario.
module tb_axis_frame_source;

  localparam int FL    = 4;
  localparam int DEPTH = 16;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic [15:0] tdata;
  logic [1:0]  tstrb;
  logic [1:0]  tkeep;
  logic        tlast;
  logic        tuser;
  logic        tvalid;
  logic        tready;
  logic        overflow;
  logic        overflow_clr;
  logic        busy;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  keep;
    logic        user;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    pos;
  int    checks;
  int    errors;

  axis_frame_source #(
    .FIFO_DEPTH(DEPTH),
    .FRAME_LEN (FL)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .enable      (enable),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .tdata       (tdata),
    .tstrb       (tstrb),
    .tkeep       (tkeep),
    .tlast       (tlast),
    .tuser       (tuser),
    .tvalid      (tvalid),
    .tready      (tready),
    .overflow    (overflow),
    .overflow_clr(overflow_clr),
    .busy        (busy)
  );

  always #5 aclk = ~aclk;

  task automatic drive(input logic en, input logic sv,
                       input logic [15:0] sd, input logic rdy,
                       input logic clr);
    @(negedge aclk);
    enable       = en;
    sample_valid = sv;
    sample_data  = sd;
    tready       = rdy;
    overflow_clr = clr;
  endtask

  task automatic push_sample(input logic [15:0] d);
    exp_q.push_back(beat_t'{data: d, keep: 2'b11,
                            user: (pos == 0),
                            last: (pos == FL-1)});
    pos = (pos + 1) % FL;
  endtask

  task automatic push_pads();
    while (pos != 0) begin
      exp_q.push_back(beat_t'{data: 16'h0000, keep: 2'b00,
                              user: (pos == 0),
                              last: (pos == FL-1)});
      pos = (pos + 1) % FL;
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h1234, 1'b1, 1'b0);
    checks++;
    if ({tvalid, tuser, tlast, tkeep, tstrb} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctl got v=%b u=%b l=%b k=%b s=%b required all 0",
               tvalid, tuser, tlast, tkeep, tstrb);
    end
    checks++;
    if ({tdata, overflow, busy} !== 18'b0) begin
      errors++;
      $display("FAIL reset_dat got d=%h ovf=%b busy=%b required 0/0/0",
               tdata, overflow, busy);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    drive(1'b0, 1'b1, 16'h1234, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    checks++;
    if ({busy, tvalid} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b v=%b required 0/0",
               busy, tvalid);
    end
  endtask

  task automatic test_frames();
    beat_t e;
    drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      if (i <= 8) begin
        drive(1'b1, 1'b1, 16'(i), 1'b1, 1'b0);
        push_sample(16'(i));
      end else begin
        drive(i < 20, 1'b0, 16'h0, 1'b1, 1'b0);
      end
      if (tvalid && tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frames_extra got d=%h required no beat", tdata);
        end else begin
          e = exp_q.pop_front();
          if ({tdata, tkeep, tstrb, tuser, tlast} !==
              {e.data, e.keep, e.keep, e.user, e.last}) begin
            errors++;
            $display("FAIL frames_beat got %h/%b/%b/%b/%b required %h/%b/%b/%b",
                     tdata, tkeep, tstrb, tuser, tlast,
                     e.data, e.keep, e.user, e.last);
          end
        end
      end
      if (i > 21 && !busy) break;
    end
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL frames_end got left=%0d busy=%b required 0/0",
               exp_q.size(), busy);
    end
  endtask

  task automatic test_overflow();
    beat_t e;
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 1'b1, 16'(i), 1'b0, 1'b0);
      if (i <= DEPTH) push_sample(16'(i));
      if (i >= 2) begin
        checks++;
        if ({tvalid, tdata} !== {1'b1, 16'h0001}) begin
          errors++;
          $display("FAIL ovf_hold got v=%b d=%h required 1/0001",
                   tvalid, tdata);
        end
      end
      if (i == 17) begin
        checks++;
        if (overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_early got %b required 0", overflow);
        end
      end
    end
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    checks++;
    if ({overflow, tdata} !== {1'b1, 16'h0001}) begin
      errors++;
      $display("FAIL ovf_set got ovf=%b d=%h required 1/0001",
               overflow, tdata);
    end
    drive(1'b1, 1'b1, 16'hbeef, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set_wins got %b required 1", overflow);
    end
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got %b required 0", overflow);
    end
    for (int i = 1; i <= 60; i++) begin
      drive(1'b0, i > 1, 16'hdead, 1'b1, 1'b0);
      if (tvalid && tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ovf_extra got d=%h required no beat", tdata);
        end else begin
          e = exp_q.pop_front();
          if ({tdata, tkeep, tuser, tlast} !==
              {e.data, e.keep, e.user, e.last}) begin
            errors++;
            $display("FAIL ovf_drain got %h/%b/%b/%b required %h/%b/%b/%b",
                     tdata, tkeep, tuser, tlast,
                     e.data, e.keep, e.user, e.last);
          end
        end
      end
      if (i > 2 && !busy) break;
    end
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_end got left=%0d busy=%b ovf=%b required 0/0/0",
               exp_q.size(), busy, overflow);
    end
  endtask

  task automatic test_pad();
    beat_t e;
    int n = 0;
    drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      if (i <= 6) begin
        drive(1'b1, 1'b1, 16'(16'h0100 + i), 1'b1, 1'b0);
        push_sample(16'(16'h0100 + i));
      end else begin
        drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        if (i == 7) push_pads();
      end
      if (tvalid && tready) begin
        n++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pad_extra got d=%h required no beat", tdata);
        end else begin
          e = exp_q.pop_front();
          if ({tdata, tkeep, tstrb, tuser, tlast} !==
              {e.data, e.keep, e.keep, e.user, e.last}) begin
            errors++;
            $display("FAIL pad_beat got %h/%b/%b/%b/%b required %h/%b/%b/%b",
                     tdata, tkeep, tstrb, tuser, tlast,
                     e.data, e.keep, e.user, e.last);
          end
        end
        if (n == 8) begin
          checks++;
          if (busy !== 1'b1) begin
            errors++;
            $display("FAIL pad_busy_last got %b required 1", busy);
          end
        end
      end
      if (i > 7 && !busy) break;
    end
    checks++;
    if (n != 8 || exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pad_end got beats=%0d left=%0d busy=%b required 8/0/0",
               n, exp_q.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    beat_t e;
    int n = 0;
    drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, i <= 3, 16'(16'h0200 + i), i <= 3, 1'b0);
      if (i <= 2) push_sample(16'(16'h0200 + i));
      if (tvalid && tready) begin
        checks++;
        e = exp_q.pop_front();
        if ({tdata, tuser, tlast} !== {e.data, e.user, e.last}) begin
          errors++;
          $display("FAIL rmid_beat got %h/%b/%b required %h/%b/%b",
                   tdata, tuser, tlast, e.data, e.user, e.last);
        end
      end
    end
    checks++;
    if ({tvalid, tdata} !== {1'b1, 16'h0203}) begin
      errors++;
      $display("FAIL rmid_pending got v=%b d=%h required 1/0203",
               tvalid, tdata);
    end
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if ({tvalid, tuser, tlast, tkeep, tstrb, tdata, busy} !== 24'b0) begin
      errors++;
      $display("FAIL rmid_async got v=%b u=%b l=%b k=%b d=%h busy=%b required 0",
               tvalid, tuser, tlast, tkeep, tdata, busy);
    end
    exp_q.delete();
    pos = 0;
    @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      if (i <= 4) begin
        drive(1'b1, i > 1, 16'(16'h0300 + i), 1'b1, 1'b0);
        if (i > 1) push_sample(16'(16'h0300 + i));
      end else begin
        drive(1'b1, i == 5, 16'h0305, 1'b1, 1'b0);
        if (i == 5) push_sample(16'h0305);
        if (i >= 6) enable = 1'b0;
      end
      if (tvalid && tready) begin
        n++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rmid_extra got d=%h k=%b required no beat",
                   tdata, tkeep);
        end else begin
          e = exp_q.pop_front();
          if ({tdata, tkeep, tuser, tlast} !==
              {e.data, e.keep, e.user, e.last}) begin
            errors++;
            $display("FAIL rmid_new got %h/%b/%b/%b required %h/%b/%b/%b",
                     tdata, tkeep, tuser, tlast,
                     e.data, e.keep, e.user, e.last);
          end
        end
      end
      if (i > 7 && !busy) break;
    end
    checks++;
    if (n != 4 || exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_end got beats=%0d left=%0d busy=%b required 4/0/0",
               n, exp_q.size(), busy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pos    = 0;
    test_reset();
    test_frames();
    test_overflow();
    test_pad();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
